// File: rtl/cnn_stream_pkg.sv
// Shared definitions for the CNN pixel streamer: image geometry, FSM state
// encoding and the digit value reported when a classification times out.
package cnn_stream_pkg;

    localparam int IMG_DIM    = 28;
    localparam int IMG_PIXELS = IMG_DIM * IMG_DIM;

    localparam logic [3:0] DIGIT_TIMEOUT = 4'hF;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        STREAM   = 3'd1,
        DRAIN    = 3'd2,
        WAIT_RES = 3'd3,
        NEXT     = 3'd4,
        DONE     = 3'd5
    } stream_state_t;

    // Plain constants so the state register stays a simple logic vector
    localparam logic [2:0] ST_IDLE     = 3'(IDLE);
    localparam logic [2:0] ST_STREAM   = 3'(STREAM);
    localparam logic [2:0] ST_DRAIN    = 3'(DRAIN);
    localparam logic [2:0] ST_WAIT_RES = 3'(WAIT_RES);
    localparam logic [2:0] ST_NEXT     = 3'(NEXT);
    localparam logic [2:0] ST_DONE     = 3'(DONE);

endpackage

// File: rtl/cnn_stream_pacer.sv
// Pixel pacer: while enabled, emits a 1-cycle issue strobe every PIXEL_GAP+1
// cycles, the first one in the very first enabled cycle.
module cnn_stream_pacer #(
    parameter int PIXEL_GAP = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic issue
);

    localparam int GW = (PIXEL_GAP > 0) ? $clog2(PIXEL_GAP + 1) : 1;

    logic [GW-1:0] gap_cnt;

    assign issue = enable && (gap_cnt == '0);

    // Gap counter reloads after each strobe and is parked at zero while disabled
    always_ff @(posedge clk) begin
        if (!rst || !enable) begin
            gap_cnt <= '0;
        end else if (gap_cnt == '0) begin
            gap_cnt <= GW'(PIXEL_GAP);
        end else begin
            gap_cnt <= gap_cnt - 1'b1;
        end
    end

endmodule

// File: rtl/cnn_pixel_streamer.sv
// CNN pixel streamer: reads 28x28 images from the image RAM one at a time,
// streams them as pixel/valid to the CNN controller, waits for the digit
// (or a timeout) and reports one result per image.
// Optional feature macro: LABEL_CHECK_EN adds a label RAM read port and a
// counter of correctly classified images.
module cnn_pixel_streamer
    import cnn_stream_pkg::*;
#(
    parameter int NUM_IMAGES     = 16,
    parameter int IMG_AW         = 14,
    parameter int PIXEL_GAP      = 0,
    parameter int TIMEOUT_CYCLES = 65535,
    localparam int IDX_W = (NUM_IMAGES > 1) ? $clog2(NUM_IMAGES) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [IMG_AW-1:0] img_rd_addr,
    input  logic [7:0]        img_rd_data,
    output logic [7:0]        pixel_o,
    output logic              pixel_o_valid,
    input  logic [3:0]        digit_i,
    input  logic              digit_i_valid,
    output logic [3:0]        result_digit,
    output logic [IDX_W-1:0]  result_idx,
    output logic              result_valid,
    output logic              timeout
`ifdef LABEL_CHECK_EN
    ,
    output logic [IDX_W-1:0]  label_rd_addr,
    input  logic [3:0]        label_rd_data,
    output logic [IDX_W:0]    correct_cnt
`endif
);

    localparam int PW = $clog2(IMG_PIXELS);
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [PW-1:0]     LAST_PIXEL = PW'(IMG_PIXELS - 1);
    localparam logic [TW-1:0]     LAST_WAIT  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(NUM_IMAGES - 1);
    localparam logic [IMG_AW-1:0] IMG_STRIDE = IMG_AW'(IMG_PIXELS);

    logic [2:0]        state;
    logic [IDX_W-1:0]  idx;
    logic [IMG_AW-1:0] base;
    logic [PW-1:0]     px_cnt;
    logic [TW-1:0]     wait_cnt;
    logic              issue;
    logic              rd_pending;

    cnn_stream_pacer #(
        .PIXEL_GAP(PIXEL_GAP)
    ) u_pacer (
        .clk   (clk),
        .rst   (rst),
        .enable(state == ST_STREAM),
        .issue (issue)
    );

    // Run sequencing: address generation, result capture and run bookkeeping
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= ST_IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            idx          <= '0;
            base         <= '0;
            img_rd_addr  <= '0;
            px_cnt       <= '0;
            wait_cnt     <= '0;
            result_valid <= 1'b0;
            timeout      <= 1'b0;
            result_digit <= '0;
            result_idx   <= '0;
        end else begin
            done         <= 1'b0;
            result_valid <= 1'b0;
            timeout      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state       <= ST_STREAM;
                        busy        <= 1'b1;
                        idx         <= '0;
                        base        <= '0;
                        img_rd_addr <= '0;
                        px_cnt      <= '0;
                    end
                end
                ST_STREAM: begin
                    if (issue) begin
                        img_rd_addr <= img_rd_addr + 1'b1;
                        if (px_cnt == LAST_PIXEL) begin
                            px_cnt <= '0;
                            state  <= ST_DRAIN;
                        end else begin
                            px_cnt <= px_cnt + 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (rd_pending) begin
                        wait_cnt <= '0;
                        state    <= ST_WAIT_RES;
                    end
                end
                ST_WAIT_RES: begin
                    if (digit_i_valid) begin
                        result_valid <= 1'b1;
                        result_digit <= digit_i;
                        result_idx   <= idx;
                        state        <= ST_NEXT;
                    end else if (wait_cnt == LAST_WAIT) begin
                        result_valid <= 1'b1;
                        timeout      <= 1'b1;
                        result_digit <= DIGIT_TIMEOUT;
                        result_idx   <= idx;
                        state        <= ST_NEXT;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_NEXT: begin
                    if (idx == LAST_IDX) begin
                        state <= ST_DONE;
                    end else begin
                        idx         <= idx + 1'b1;
                        base        <= base + IMG_STRIDE;
                        img_rd_addr <= base + IMG_STRIDE;
                        state       <= ST_STREAM;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Pixel output stage: RAM data lands one cycle after the issue, then is registered
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_pending    <= 1'b0;
            pixel_o_valid <= 1'b0;
            pixel_o       <= '0;
        end else begin
            rd_pending    <= issue;
            pixel_o_valid <= rd_pending;
            if (rd_pending) begin
                pixel_o <= img_rd_data;
            end
        end
    end

`ifdef LABEL_CHECK_EN
    logic [3:0] label_q;

    assign label_rd_addr = idx;

    // Label capture during streaming and scoring of non-timeout results
    always_ff @(posedge clk) begin
        if (!rst) begin
            label_q     <= '0;
            correct_cnt <= '0;
        end else begin
            if (state == ST_STREAM) begin
                label_q <= label_rd_data;
            end
            if (state == ST_IDLE && start) begin
                correct_cnt <= '0;
            end else if (state == ST_WAIT_RES && digit_i_valid && digit_i == label_q) begin
                correct_cnt <= correct_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cnn_pixel_streamer.sv
// Testbench for cnn_pixel_streamer: a back-to-back instance driven through
// digit results, a timeout, ignored pulses and a mid-run reset, plus a
// PIXEL_GAP=3 instance that times out on every image.
module tb_cnn_pixel_streamer;

    localparam int AW  = 14;
    localparam int TMO = 100;
    localparam int PIX = 784;

    logic clk = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;

    // Cycle counter used to time results and pixel spacing
    always @(posedge clk) cyc <= cyc + 1;

    logic          rst_a, start_a, busy_a, done_a, pv_a, dv_a, rv_a, to_a;
    logic [AW-1:0] addr_a;
    logic [7:0]    rd_a, pix_a;
    logic [3:0]    dig_a, rdig_a;
    logic [0:0]    ridx_a;

    logic          rst_b, start_b, busy_b, done_b, pv_b, rv_b, to_b;
    logic [AW-1:0] addr_b;
    logic [7:0]    rd_b, pix_b;
    logic [3:0]    rdig_b;
    logic [0:0]    ridx_b;

`ifdef LABEL_CHECK_EN
    logic [0:0] lab_addr_a, lab_addr_b;
    logic [3:0] lab_a, lab_b;
    logic [1:0] correct_a, correct_b;
`endif

    cnn_pixel_streamer #(
        .NUM_IMAGES(2), .IMG_AW(AW), .PIXEL_GAP(0), .TIMEOUT_CYCLES(TMO)
    ) dut_a (
        .clk(clk), .rst(rst_a), .start(start_a), .busy(busy_a), .done(done_a),
        .img_rd_addr(addr_a), .img_rd_data(rd_a), .pixel_o(pix_a), .pixel_o_valid(pv_a),
        .digit_i(dig_a), .digit_i_valid(dv_a), .result_digit(rdig_a), .result_idx(ridx_a),
        .result_valid(rv_a), .timeout(to_a)
`ifdef LABEL_CHECK_EN
        , .label_rd_addr(lab_addr_a), .label_rd_data(lab_a), .correct_cnt(correct_a)
`endif
    );

    cnn_pixel_streamer #(
        .NUM_IMAGES(2), .IMG_AW(AW), .PIXEL_GAP(3), .TIMEOUT_CYCLES(TMO)
    ) dut_b (
        .clk(clk), .rst(rst_b), .start(start_b), .busy(busy_b), .done(done_b),
        .img_rd_addr(addr_b), .img_rd_data(rd_b), .pixel_o(pix_b), .pixel_o_valid(pv_b),
        .digit_i(4'd0), .digit_i_valid(1'b0), .result_digit(rdig_b), .result_idx(ridx_b),
        .result_valid(rv_b), .timeout(to_b)
`ifdef LABEL_CHECK_EN
        , .label_rd_addr(lab_addr_b), .label_rd_data(lab_b), .correct_cnt(correct_b)
`endif
    );

    // Image RAMs with 1-cycle registered read, word i holds i[7:0]
    always @(posedge clk) begin
        rd_a <= addr_a[7:0];
        rd_b <= addr_b[7:0];
    end

`ifdef LABEL_CHECK_EN
    // Label RAMs: labels {7,3} for instance A, zeros for instance B
    always @(posedge clk) begin
        lab_a <= (lab_addr_a == 1'b0) ? 4'd7 : 4'd3;
        lab_b <= 4'd0;
    end
`endif

    typedef struct {
        logic [7:0] pix;
        int         addr;
        bit         first;
    } pix_exp_t;

    typedef struct {
        logic [3:0] digit;
        int         idx;
        logic       tmo;
        int         at;
    } res_exp_t;

    pix_exp_t pixQ[$];
    res_exp_t resQ[$];

    int compared   = 0;
    int mismatched = 0;
    int pixSeenA   = 0;
    int lastValidA = 0;
    int doneSeenA  = 0;
    int pixSeenB   = 0;
    int resSeenB   = 0;
    int doneSeenB  = 0;
    bit bFinished  = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic reportError(input string name, input string got, input string req);
        compared++;
        mismatched++;
        $display("[TB] FAIL %s: got %s, expected %s (cycle %0d)", name, got, req, cyc);
    endtask

    // One-cycle pulse on start and/or digit_i_valid of instance A
    task automatic applyStimulus(input bit doStart, input bit doDigit, input logic [3:0] digit);
        start_a = doStart;
        dv_a    = doDigit;
        dig_a   = digit;
        @(negedge clk); #1;
        start_a = 1'b0;
        dv_a    = 1'b0;
    endtask

    task automatic queuePixels();
        pix_exp_t e;
        for (int a = 0; a < 2 * PIX; a++) begin
            e.pix   = 8'(a);
            e.addr  = a;
            e.first = (a % PIX) == 0;
            pixQ.push_back(e);
        end
    endtask

    task automatic waitPixels(input int target);
        int n;
        n = 0;
        while (pixSeenA < target && n < 3000) begin
            @(negedge clk); #1;
            n++;
        end
        if (pixSeenA < target) reportError("wait_pixels_a", $sformatf("%0d pixels", pixSeenA), $sformatf("%0d pixels", target));
    endtask

    task automatic waitDone(input int target);
        int n;
        n = 0;
        while (doneSeenA < target && n < 500) begin
            @(negedge clk); #1;
            n++;
        end
        if (doneSeenA < target) reportError("wait_done_a", $sformatf("%0d done", doneSeenA), $sformatf("%0d done", target));
    endtask

    // Digit pulse 10 cycles after WAIT_RES entry, which coincides with the last pixel
    task automatic sendDigit(input logic [3:0] digit, input int imgIdx);
        res_exp_t r;
        while (cyc < lastValidA + 10) begin
            @(negedge clk); #1;
        end
        r.digit = digit;
        r.idx   = imgIdx;
        r.tmo   = 1'b0;
        r.at    = cyc + 1;
        resQ.push_back(r);
        applyStimulus(1'b0, 1'b1, digit);
    endtask

    task automatic checkAllZeroA(input string tag);
        checkOutput({tag, "_busy"}, 32'(busy_a), 32'd0);
        checkOutput({tag, "_done"}, 32'(done_a), 32'd0);
        checkOutput({tag, "_pixel_valid"}, 32'(pv_a), 32'd0);
        checkOutput({tag, "_pixel"}, 32'(pix_a), 32'd0);
        checkOutput({tag, "_addr"}, 32'(addr_a), 32'd0);
        checkOutput({tag, "_result_valid"}, 32'(rv_a), 32'd0);
        checkOutput({tag, "_timeout"}, 32'(to_a), 32'd0);
        checkOutput({tag, "_result_digit"}, 32'(rdig_a), 32'd0);
        checkOutput({tag, "_result_idx"}, 32'(ridx_a), 32'd0);
    endtask

    // Monitor A: pops expected pixels and results whenever the DUT presents them
    initial begin : monitorA
        pix_exp_t      pe;
        res_exp_t      re;
        logic [AW-1:0] ah1, ah2;
        ah1 = '0;
        ah2 = '0;
        forever begin
            @(negedge clk);
            if (pv_a) begin
                if (pixQ.size() == 0) begin
                    reportError("pixel_a_unexpected", "extra pixel", "no pixel");
                end else begin
                    pe = pixQ.pop_front();
                    checkOutput("pixel_a_value", 32'(pix_a), 32'(pe.pix));
                    checkOutput("pixel_a_addr", 32'(ah2), 32'(pe.addr));
                    if (!pe.first) checkOutput("pixel_a_spacing", 32'(cyc - lastValidA), 32'd1);
                end
                lastValidA = cyc;
                pixSeenA++;
            end
            if (rv_a) begin
                if (resQ.size() == 0) begin
                    reportError("result_a_unexpected", "result_valid", "no result");
                end else begin
                    re = resQ.pop_front();
                    checkOutput("result_a_digit", 32'(rdig_a), 32'(re.digit));
                    checkOutput("result_a_idx", 32'(ridx_a), 32'(re.idx));
                    checkOutput("result_a_timeout", 32'(to_a), 32'(re.tmo));
                    checkOutput("result_a_cycle", 32'(cyc), 32'(re.at));
                end
            end
            if (done_a) begin
                doneSeenA++;
                checkOutput("busy_a_at_done", 32'(busy_a), 32'd0);
            end
            ah2 = ah1;
            ah1 = addr_a;
        end
    end

    // Monitor B: gap-3 stream, expected pixel k is k[7:0] from address k, every 4th cycle
    initial begin : monitorB
        int            lastB;
        logic [AW-1:0] bh1, bh2;
        lastB = 0;
        bh1   = '0;
        bh2   = '0;
        forever begin
            @(negedge clk);
            if (pv_b) begin
                checkOutput("pixel_b_value", 32'(pix_b), 32'(pixSeenB % 256));
                checkOutput("pixel_b_addr", 32'(bh2), 32'(pixSeenB));
                if (pixSeenB % PIX != 0) checkOutput("pixel_b_spacing", 32'(cyc - lastB), 32'd4);
                lastB = cyc;
                pixSeenB++;
            end
            if (rv_b) begin
                checkOutput("result_b_timeout", 32'(to_b), 32'd1);
                checkOutput("result_b_digit", 32'(rdig_b), 32'hF);
                checkOutput("result_b_idx", 32'(ridx_b), 32'(resSeenB));
                resSeenB++;
            end
            if (done_b) doneSeenB++;
            bh2 = bh1;
            bh1 = addr_b;
        end
    end

    // Stimulus B: one run with no digits, so both images time out
    initial begin : stimulusB
        int n;
        rst_b   = 1'b0;
        start_b = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        rst_b = 1'b1;
        @(negedge clk); #1;
        start_b = 1'b1;
        @(negedge clk); #1;
        start_b = 1'b0;
        n = 0;
        while (doneSeenB == 0 && n < 9000) begin
            @(negedge clk); #1;
            n++;
        end
        if (doneSeenB == 0) reportError("wait_done_b", "no done", "done pulse");
        checkOutput("pixel_b_count", 32'(pixSeenB), 32'(2 * PIX));
        checkOutput("result_b_count", 32'(resSeenB), 32'd2);
        bFinished = 1'b1;
    end

    // Stimulus A: reset state, full run, mid-run reset, then a scored run
    initial begin : stimulusA
        int       base;
        int       n;
        res_exp_t r;
        rst_a   = 1'b0;
        start_a = 1'b0;
        dv_a    = 1'b0;
        dig_a   = 4'd0;
        repeat (3) @(negedge clk);
        #1;
        checkAllZeroA("reset");
        rst_a = 1'b1;
        @(negedge clk); #1;

        $display("[TB] run 1: digit 7 for image 0, timeout for image 1");
        base = pixSeenA;
        queuePixels();
        applyStimulus(1'b1, 1'b0, 4'd0);
        checkOutput("busy_after_start", 32'(busy_a), 32'd1);
        waitPixels(base + 100);
        applyStimulus(1'b0, 1'b1, 4'd2);
        waitPixels(base + 200);
        applyStimulus(1'b1, 1'b0, 4'd0);
        waitPixels(base + PIX);
        sendDigit(4'd7, 0);
        waitPixels(base + 2 * PIX);
        r.digit = 4'hF;
        r.idx   = 1;
        r.tmo   = 1'b1;
        r.at    = lastValidA + TMO;
        resQ.push_back(r);
        waitDone(1);
`ifdef LABEL_CHECK_EN
        checkOutput("correct_cnt_run1", 32'(correct_a), 32'd1);
`endif

        $display("[TB] run 2: reset after pixel 400");
        repeat (3) @(negedge clk);
        #1;
        base = pixSeenA;
        queuePixels();
        applyStimulus(1'b1, 1'b0, 4'd0);
        waitPixels(base + 400);
        rst_a = 1'b0;
        @(posedge clk); #1;
        checkAllZeroA("midrun_reset");
        pixQ.delete();
        @(negedge clk); #1;
        rst_a = 1'b1;
        @(negedge clk); #1;

        $display("[TB] run 3: digits 7 and 5");
        base = pixSeenA;
        queuePixels();
        applyStimulus(1'b1, 1'b0, 4'd0);
        waitPixels(base + PIX);
        sendDigit(4'd7, 0);
        waitPixels(base + 2 * PIX);
        sendDigit(4'd5, 1);
        waitDone(2);
`ifdef LABEL_CHECK_EN
        checkOutput("correct_cnt_run3", 32'(correct_a), 32'd1);
`endif

        n = 0;
        while (!bFinished && n < 12000) begin
            @(negedge clk); #1;
            n++;
        end
        if (!bFinished) reportError("wait_instance_b", "still running", "finished");
        repeat (5) @(negedge clk);
        checkOutput("done_count_a", 32'(doneSeenA), 32'd2);
        checkOutput("pixels_left_a", 32'(pixQ.size()), 32'd0);
        checkOutput("results_left_a", 32'(resQ.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
